// File: rtl/mips_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_run_ctrl_pkg
//  Description : Shared state, command and halt-cause encodings for the
//                MIPS run-control sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_run_ctrl_pkg;

  localparam int c_CNT_W_DEF  = 32;
  localparam int c_STEP_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_HALT    = 2'd0,
    OP_RUN     = 2'd1,
    OP_STEP    = 2'd2,
    OP_CLR_CNT = 2'd3
  } cmd_op_t;

  typedef enum logic [2:0] {
    CAUSE_RESET     = 3'd0,
    CAUSE_CMD       = 3'd1,
    CAUSE_BP        = 3'd2,
    CAUSE_STEP      = 3'd3,
    CAUSE_SELF_LOOP = 3'd4
  } halt_cause_t;

  // Instruction addresses are word aligned, so the byte offset never matters.
  function automatic logic pc_word_eq(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage : mips_run_ctrl_pkg
`default_nettype wire

// File: rtl/mips_run_ctrl_bp_match.sv
`default_nettype none
// ============================================================================
//  Module      : mips_bp_match
//  Description : Word-aligned PC breakpoint comparator with enable and
//                one-shot skip qualifiers.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_bp_match
  import mips_run_ctrl_pkg::*;
(
  input  logic        i_en,
  input  logic        i_skip,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_bp_addr,
  output logic        o_match,
  output logic        o_hit
);

  assign o_match = i_en & pc_word_eq(i_pc, i_bp_addr);
  // o_match ignores skip so the sequencer can arm skip when resuming on the bp.
  assign o_hit   = o_match & ~i_skip;

endmodule : mips_bp_match
`default_nettype wire

// File: rtl/mips_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_run_ctrl
//  Description : Run-control sequencer (halt / run / N-step / PC breakpoint)
//                gating the single-cycle MIPS core through a clock enable.
//                Optional self-loop halt: define MIPS_RUN_CTRL_SELF_LOOP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_run_ctrl
  import mips_run_ctrl_pkg::*;
#(
  parameter int CNT_W  = c_CNT_W_DEF,
  parameter int STEP_W = c_STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_op,
  input  logic [STEP_W-1:0] i_cmd_arg,
  input  logic              i_bp_en,
  input  logic [31:0]       i_bp_addr,
  input  logic [31:0]       i_pc_current,
  output logic              o_cpu_en,
  output logic              o_halted,
  output logic [2:0]        o_halt_cause,
  output logic [CNT_W-1:0]  o_cyc_cnt,
  output logic [CNT_W-1:0]  o_ret_cnt
);

  state_t            r_state;
  halt_cause_t       r_cause;
  logic [STEP_W-1:0] r_step_left;
  logic              r_bp_skip;
  logic [CNT_W-1:0]  r_cyc_cnt;
  logic [CNT_W-1:0]  r_ret_cnt;

  logic w_bp_match;
  logic w_bp_hit;
  logic w_active;
  logic w_cpu_en;
  logic w_accept;
  logic w_step_done;
  logic w_self_loop;
  logic w_unused_bits;

  mips_bp_match u_bp_match (
    .i_en      (i_bp_en),
    .i_skip    (r_bp_skip),
    .i_pc      (i_pc_current),
    .i_bp_addr (i_bp_addr),
    .o_match   (w_bp_match),
    .o_hit     (w_bp_hit)
  );

  assign w_active    = (r_state != ST_HALTED);
  assign w_cpu_en    = w_active & ~w_bp_hit;
  assign o_cmd_ready = ~w_active | (i_cmd_op == OP_HALT) | (i_cmd_op == OP_CLR_CNT);
  assign w_accept    = i_cmd_valid & o_cmd_ready;
  assign w_step_done = (r_state == ST_STEPPING) & w_cpu_en & (r_step_left == STEP_W'(1));

`ifdef MIPS_RUN_CTRL_SELF_LOOP_EN
  logic [31:0] r_last_pc;
  logic        r_last_pc_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_pc     <= '0;
      r_last_pc_vld <= 1'b0;
    end else if (!w_active) begin
      r_last_pc_vld <= 1'b0;
    end else if (w_cpu_en) begin
      r_last_pc     <= i_pc_current;
      r_last_pc_vld <= 1'b1;
    end
  end

  assign w_self_loop   = w_cpu_en & r_last_pc_vld & (i_pc_current == r_last_pc);
  assign w_unused_bits = 1'b0;
`else
  assign w_self_loop   = 1'b0;
  assign w_unused_bits = ^{i_pc_current[1:0], i_bp_addr[1:0]};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_HALTED;
      r_cause     <= CAUSE_RESET;
      r_step_left <= '0;
      r_bp_skip   <= 1'b0;
      r_cyc_cnt   <= '0;
      r_ret_cnt   <= '0;
    end else begin
      if (w_accept && (i_cmd_op == OP_CLR_CNT)) begin
        r_cyc_cnt <= '0;
        r_ret_cnt <= '0;
      end else begin
        if (w_active) r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
        if (w_cpu_en) r_ret_cnt <= r_ret_cnt + CNT_W'(1);
      end

      if (w_cpu_en) r_bp_skip <= 1'b0;

      case (r_state)
        ST_HALTED: begin
          // Resuming on the breakpoint PC must execute that instruction once.
          if (w_accept && (i_cmd_op == OP_RUN)) begin
            r_state   <= ST_RUNNING;
            r_bp_skip <= w_bp_match;
          end else if (w_accept && (i_cmd_op == OP_STEP)) begin
            r_state     <= ST_STEPPING;
            r_step_left <= (i_cmd_arg == '0) ? STEP_W'(1) : i_cmd_arg;
            r_bp_skip   <= w_bp_match;
          end
        end
        ST_RUNNING, ST_STEPPING: begin
          if ((r_state == ST_STEPPING) && w_cpu_en)
            r_step_left <= r_step_left - STEP_W'(1);
          if (w_bp_hit) begin
            r_state <= ST_HALTED;
            r_cause <= CAUSE_BP;
          end else if (w_step_done) begin
            r_state <= ST_HALTED;
            r_cause <= CAUSE_STEP;
          end else if (w_self_loop) begin
            r_state <= ST_HALTED;
            r_cause <= CAUSE_SELF_LOOP;
          end else if (w_accept && (i_cmd_op == OP_HALT)) begin
            r_state <= ST_HALTED;
            r_cause <= CAUSE_CMD;
          end
        end
        default: r_state <= ST_HALTED;
      endcase
    end
  end

  assign o_cpu_en     = w_cpu_en;
  assign o_halted     = ~w_active;
  assign o_halt_cause = r_cause;
  assign o_cyc_cnt    = r_cyc_cnt;
  assign o_ret_cnt    = r_ret_cnt;

endmodule : mips_run_ctrl
`default_nettype wire
